// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage controller and its ALU.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    NOT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } exec_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one write port shared by load and writeback.
// Optional debug read port when ALU_EXEC_DBG_EN is defined.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int  NREGS = 4,
  parameter int  W     = ALU_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef ALU_EXEC_DBG_EN
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data,
`endif
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic [AW-1:0] rd_addr_a,
  output logic [W-1:0]  rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [W-1:0]  rd_data_b
);

  logic [W-1:0]  mem_q [NREGS];
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;

  // Loads are only accepted in IDLE and writeback only happens in WB, so they never collide.
  always_comb begin
    we    = ld_we | wb_we;
    waddr = wb_we ? wb_addr : ld_addr;
    wdata = wb_we ? wb_data : ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

`ifdef ALU_EXEC_DBG_EN
  assign dbg_data = mem_q[dbg_addr];
`endif

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: IDLE -> EXEC -> WB sequencing around a combinational ALU.
// Define ALU_EXEC_DBG_EN to expose a combinational register-file debug read port.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int  NREGS = 4,
  parameter int  W     = ALU_W,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_rd,
  input  logic [AW-1:0] req_rs,
  input  logic [AW-1:0] req_rt,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [1:0]    alu_op,
  input  logic [W-1:0]  alu_result,
  input  logic          alu_zero,
  input  logic          alu_neg,
  output logic          done,
  output logic [W-1:0]  wb_data,
  output logic          flag_zero,
  output logic          flag_neg,
`ifdef ALU_EXEC_DBG_EN
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data,
`endif
  output logic          busy
);

  exec_state_t   state_q;
  alu_op_t       op_q;
  logic [AW-1:0] rd_q;
  logic [W-1:0]  a_q, b_q, res_q;
  logic          zero_q, neg_q;
  logic          flag_zero_q, flag_neg_q;
  logic [W-1:0]  rdata_a, rdata_b;
  logic          ld_fire, req_fire, wb_we;

  assign ld_ready  = (state_q == IDLE);
  assign req_ready = (state_q == IDLE) && !ld_valid;
  assign ld_fire   = ld_valid && ld_ready;
  assign req_fire  = req_valid && req_ready;
  assign wb_we     = (state_q == WB);

  alu_regfile #(.NREGS(NREGS), .W(W)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ALU_EXEC_DBG_EN
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
`endif
    .ld_we     (ld_fire),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wb_we     (wb_we),
    .wb_addr   (rd_q),
    .wb_data   (res_q),
    .rd_addr_a (req_rs),
    .rd_data_a (rdata_a),
    .rd_addr_b (req_rt),
    .rd_data_b (rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= ADD;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      flag_zero_q <= 1'b0;
      flag_neg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            op_q    <= alu_op_t'(req_op);
            rd_q    <= req_rd;
            a_q     <= rdata_a;
            b_q     <= rdata_b;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= alu_result;
          zero_q  <= alu_zero;
          neg_q   <= alu_neg;
          state_q <= WB;
        end
        WB: begin
          flag_zero_q <= zero_q;
          flag_neg_q  <= neg_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operands stay registered outside EXEC, so the ALU inputs only move on accept.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign done      = wb_we;
  assign wb_data   = res_q;
  assign flag_zero = flag_zero_q;
  assign flag_neg  = flag_neg_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural ALU attached.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  localparam int NREGS = 4;
  localparam int W     = 8;
  localparam int AW    = 2;

  logic          clk, rst_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_rd, req_rs, req_rt;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [1:0]    alu_op;
  logic          alu_zero, alu_neg;
  logic          done, flag_zero, flag_neg, busy;
  logic [W-1:0]  wb_data;
`ifdef ALU_EXEC_DBG_EN
  logic [AW-1:0] dbg_addr;
  logic [W-1:0]  dbg_data;
`endif

  alu_exec_ctrl #(.NREGS(NREGS), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rd     (req_rd),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .done       (done),
    .wb_data    (wb_data),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
`ifdef ALU_EXEC_DBG_EN
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
`endif
    .busy       (busy)
  );

  function automatic logic [W-1:0] alu_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return ~a;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_ref(alu_op, alu_a, alu_b);
    alu_zero   = (alu_result == '0);
    alu_neg    = alu_result[W-1];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] rf_m [NREGS];
  int           checks = 0;
  int           passes = 0;
  bit           pend_flag = 0;
  logic         pz, pn;

  // Writeback monitor: pops the scoreboard on each done, checks flags one cycle later.
  always @(negedge clk) begin
    if (pend_flag) begin
      pend_flag = 0;
      checks++;
      if ({flag_zero, flag_neg} !== {pz, pn})
        $display("FAIL flags: got z=%b n=%b, want z=%b n=%b", flag_zero, flag_neg, pz, pn);
      else passes++;
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: done high at cycle %0d with nothing outstanding", cyc);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (wb_data !== mon_e.data)
          $display("FAIL wb_data: got %h, want %h", wb_data, mon_e.data);
        else passes++;
        checks++;
        if (cyc !== mon_e.acc + 2)
          $display("FAIL done_latency: done at cycle %0d, want %0d", cyc, mon_e.acc + 2);
        else passes++;
        pz = (mon_e.data == '0);
        pn = mon_e.data[W-1];
        pend_flag = 1;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int rd, input int rs, input int rt, output int acc);
    logic [W-1:0] a, b, r;
    bit ok;
    a  = rf_m[rs];
    b  = rf_m[rt];
    r  = alu_ref(op, a, b);
    ok = 0;
    acc = -1;
    req_valid = 1'b1;
    req_op    = op;
    req_rd    = rd[AW-1:0];
    req_rs    = rs[AW-1:0];
    req_rt    = rt[AW-1:0];
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (req_ready === 1'b1) begin
        ok  = 1;
        acc = cyc;
        sb.push_back('{r, cyc});
        rf_m[rd] = r;
      end else if (ld_valid === 1'b0) begin
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_wait: busy=%b while not ready, want 1", busy);
        else passes++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (!ok) $display("FAIL issue_timeout: req_ready=%b, want 1 within 20 cycles", req_ready);
    else passes++;
    if (ok) begin
      checks++;
      if ({alu_a, alu_b, alu_op} !== {a, b, op})
        $display("FAIL exec_operands: got a=%h b=%h op=%b, want a=%h b=%h op=%b", alu_a, alu_b, alu_op, a, b, op);
      else passes++;
    end
  endtask

  task automatic load(input int addr, input logic [W-1:0] d);
    ld_valid = 1'b1;
    ld_addr  = addr[AW-1:0];
    ld_data  = d;
    #1;
    checks++;
    if (ld_ready !== 1'b1) $display("FAIL ld_ready: got %b, want 1", ld_ready);
    else passes++;
    rf_m[addr] = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0 && !pend_flag) break;
      @(negedge clk);
      #2;
    end
    checks++;
    if (sb.size() != 0 || pend_flag)
      $display("FAIL drain_timeout: %0d writebacks outstanding, want 0", sb.size());
    else passes++;
  endtask

  task automatic check_reset_outputs(input logic ldv);
    checks++;
    if ({done, busy, flag_zero, flag_neg, ld_ready, req_ready} !== {5'b00001, ~ldv})
      $display("FAIL reset_ctrl: done=%b busy=%b fz=%b fn=%b ldr=%b rqr=%b", done, busy, flag_zero, flag_neg, ld_ready, req_ready);
    else passes++;
    checks++;
    if ({wb_data, alu_a, alu_b, alu_op} !== '0)
      $display("FAIL reset_data: wb=%h a=%h b=%h op=%b, want all 0", wb_data, alu_a, alu_b, alu_op);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs(1'b0);
    ld_valid = 1'b1;
    #1;
    check_reset_outputs(1'b1);
    ld_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) rf_m[i] = '0;
  endtask

  task automatic test_add_basic();
    int acc;
    load(0, 8'd1);
    load(1, 8'd3);
    issue(ADD, 2, 0, 1, acc);
    drain();
    issue(AND, 3, 2, 2, acc);
    drain();
  endtask

  task automatic test_flags();
    int acc;
    load(0, 8'd100);
    load(1, 8'd100);
    issue(ADD, 2, 0, 1, acc);
    drain();
    issue(SUB, 3, 0, 0, acc);
    drain();
    load(0, 8'h12);
    issue(NOT, 1, 0, 0, acc);
    drain();
    load(2, 8'hFF);
    issue(NOT, 3, 2, 2, acc);
    drain();
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    load(0, 8'd5);
    load(1, 8'd9);
    issue(ADD, 2, 0, 1, a0);
    issue(SUB, 3, 2, 0, a1);
    issue(ADD, 0, 3, 2, a2);
    checks++;
    if (a1 - a0 !== 3) $display("FAIL b2b_gap1: got %0d cycles, want 3", a1 - a0);
    else passes++;
    checks++;
    if (a2 - a1 !== 3) $display("FAIL b2b_gap2: got %0d cycles, want 3", a2 - a1);
    else passes++;
    drain();
  endtask

  task automatic test_ld_priority();
    int t0, acc;
    ld_valid  = 1'b1;
    ld_addr   = 2'd0;
    ld_data   = 8'd7;
    req_valid = 1'b1;
    req_op    = ADD;
    req_rd    = 2'd3;
    req_rs    = 2'd0;
    req_rt    = 2'd0;
    #1;
    checks++;
    if ({ld_ready, req_ready} !== 2'b10)
      $display("FAIL ld_priority: ld_ready=%b req_ready=%b, want 1/0", ld_ready, req_ready);
    else passes++;
    rf_m[0] = 8'd7;
    t0 = cyc;
    @(negedge clk);
    ld_valid = 1'b0;
    issue(ADD, 3, 0, 0, acc);
    checks++;
    if (acc !== t0 + 1) $display("FAIL ld_then_req: accept cycle %0d, want %0d", acc, t0 + 1);
    else passes++;
    drain();
  endtask

  task automatic test_reset_mid_exec();
    int acc;
    load(0, 8'd40);
    load(1, 8'd2);
    issue(ADD, 2, 0, 1, acc);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1'b0);
    sb.delete();
    for (int i = 0; i < NREGS; i++) rf_m[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NREGS; i++) begin
      issue(AND, i, i, i, acc);
      drain();
    end
    load(0, 8'd5);
    load(1, 8'd6);
    issue(ADD, 2, 0, 1, acc);
    drain();
    issue(AND, 3, 2, 2, acc);
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_rd    = '0;
    req_rs    = '0;
    req_rt    = '0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
`ifdef ALU_EXEC_DBG_EN
    dbg_addr  = '0;
`endif
    test_reset();
    test_add_basic();
    test_flags();
    test_back_to_back();
    test_ld_priority();
    test_reset_mid_exec();
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
